// File: rtl/psec5_spi_pkg.sv
// Shared types and frame-width helpers for the PSEC5 SPI configuration slave.
package psec5_spi_pkg;

   typedef enum logic {ADDR, DATA} spi_state_t;

   localparam int SPI_ADDR_W_DEF = 8;
   localparam int SPI_DATA_W_DEF = 8;

   // The read/write flag is the MSB of the address word.
   function automatic int spi_rnw_bit(input int addr_w);
      return addr_w - 1;
   endfunction

   function automatic int spi_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_bit_shifter.sv
// LSB-first serial capture / parallel-load shift-out with bit counter; done is combinational on the last-bit edge.
// No backpressure: one bit per enabled sclk edge, clr discards the partial word.
module spi_bit_shifter #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          i_sclk,
   input  logic          i_rstn,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic          i_dir_out,
   input  logic          i_load,
   input  logic [W-1:0]  i_load_dat,
   input  logic [CW-1:0] i_last_idx,
   input  logic          i_sin,
   output logic [W-1:0]  o_cap_dat,
   output logic          o_sout,
   output logic [CW-1:0] o_cnt,
   output logic          o_done
);

   logic [W-1:0]  r_sh;
   logic [CW-1:0] r_cnt;
   logic          r_sout;
   logic [W-1:0]  w_cap;

   // Incoming bit lands at its own position so the word is complete on the last edge.
   always_comb begin
      w_cap = r_sh;
      for (int i = 0; i < W; i++) begin
         if (r_cnt == CW'(i)) w_cap[i] = i_sin;
      end
   end

   assign o_done = i_en && (r_cnt == i_last_idx);

   always_ff @(posedge i_sclk) begin
      if (!i_rstn) begin
         r_sh   <= '0;
         r_cnt  <= '0;
         r_sout <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_sout <= 1'b0;
      end else begin
         if (i_en) r_cnt <= o_done ? '0 : r_cnt + CW'(1);
         if (i_load) begin
            r_sh   <= i_load_dat;
            r_sout <= i_load_dat[0];
         end else if (i_en && i_dir_out) begin
            r_sh   <= r_sh >> 1;
            r_sout <= r_sh[1];
         end else if (i_en) begin
            r_sh   <= w_cap;
            r_sout <= 1'b0;
         end
      end
   end

   assign o_cap_dat = w_cap;
   assign o_sout    = r_sout;
   assign o_cnt     = r_cnt;

endmodule

// File: rtl/spi_cfg_reg_bank.sv
// SPI slave decoding {addr, data} frames into NUM_REGS config registers with read-back and burst auto-increment.
// Writes land on the last data-bit edge; no backpressure, cs_n high aborts the frame.
module spi_cfg_reg_bank
   import psec5_spi_pkg::*;
#(
   parameter int                         DATA_W    = SPI_DATA_W_DEF,
   parameter int                         ADDR_W    = SPI_ADDR_W_DEF,
   parameter int                         NUM_REGS  = 4,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
   parameter logic [NUM_REGS-1:0]        RO_MASK   = '0
) (
   input  logic                         sclk,
   input  logic                         rstn,
   input  logic                         cs_n,
   input  logic                         serial_in,
   output logic                         serial_out,
   input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out,
   output logic [ADDR_W-2:0]            select_reg,
   output logic [NUM_REGS-1:0]          wr_strobe,
   output logic                         frame_err,
   output logic                         busy
);

   localparam int IDX_W = ADDR_W - 1;
   localparam int RNW   = spi_rnw_bit(ADDR_W);
   localparam int SH_W  = spi_max(ADDR_W, DATA_W);
   localparam int CW    = $clog2(SH_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
   localparam logic [CW-1:0]    ADDR_LAST = CW'(ADDR_W - 1);
   localparam logic [CW-1:0]    DATA_LAST = CW'(DATA_W - 1);

   spi_state_t                 r_state;
   spi_state_t                 w_state_nxt;
   logic [IDX_W-1:0]           r_idx;
   logic                       r_rnw;
   logic [NUM_REGS*DATA_W-1:0] r_regs;
   logic [IDX_W-1:0]           r_sel;
   logic [NUM_REGS-1:0]        r_wr_strobe;
   logic                       r_frame_err;

   logic [SH_W-1:0]            w_cap;
   logic                       w_sout;
   logic [CW-1:0]              w_cnt;
   logic                       w_done;
   logic [CW-1:0]              w_last_idx;
   logic [IDX_W-1:0]           w_addr_idx;
   logic                       w_addr_rnw;
   logic [IDX_W-1:0]           w_next_idx;
   logic [IDX_W-1:0]           w_load_idx;
   logic [DATA_W-1:0]          w_rd_word;
   logic [NUM_REGS-1:0]        w_hit;
   logic                       w_dir_out;
   logic                       w_load;
   logic [NUM_REGS-1:0]        w_strobe_nxt;
   logic                       w_err_nxt;

   assign w_last_idx = (r_state == ADDR) ? ADDR_LAST : DATA_LAST;
   assign w_dir_out  = (r_state == DATA) && r_rnw;

   spi_bit_shifter #(.W(SH_W), .CW(CW)) u_shifter (
      .i_sclk     (sclk),
      .i_rstn     (rstn),
      .i_clr      (cs_n),
      .i_en       (!cs_n),
      .i_dir_out  (w_dir_out),
      .i_load     (w_load),
      .i_load_dat (SH_W'(w_rd_word)),
      .i_last_idx (w_last_idx),
      .i_sin      (serial_in),
      .o_cap_dat  (w_cap),
      .o_sout     (w_sout),
      .o_cnt      (w_cnt),
      .o_done     (w_done)
   );

   assign w_addr_idx = w_cap[IDX_W-1:0];
   assign w_addr_rnw = w_cap[RNW];
   assign w_next_idx = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
   assign w_load_idx = (r_state == ADDR) ? w_addr_idx : w_next_idx;

   // Out-of-range indices match no register and read back as zero.
   always_comb begin
      w_rd_word = '0;
      w_hit     = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_load_idx == IDX_W'(i))
            w_rd_word = RO_MASK[i] ? ro_in[i*DATA_W +: DATA_W] : r_regs[i*DATA_W +: DATA_W];
         w_hit[i] = (r_idx == IDX_W'(i));
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_strobe_nxt = '0;
      w_err_nxt    = 1'b0;
      if (cs_n) begin
         w_state_nxt = ADDR;
         w_err_nxt   = (w_cnt != '0);
      end else if (w_done) begin
         case (r_state)
            ADDR: begin
               w_state_nxt = DATA;
               w_load      = w_addr_rnw;
            end
            DATA: begin
               w_load = r_rnw;
               if (r_rnw) begin
                  w_err_nxt = ~|w_hit;
               end else begin
                  w_strobe_nxt = w_hit & ~RO_MASK;
                  w_err_nxt    = ~|(w_hit & ~RO_MASK);
               end
            end
            default: w_state_nxt = ADDR;
         endcase
      end
   end

   always_ff @(posedge sclk) begin
      if (!rstn) r_state <= ADDR;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge sclk) begin
      if (!rstn) begin
         r_idx       <= '0;
         r_rnw       <= 1'b0;
         r_regs      <= RESET_VAL;
         r_sel       <= '0;
         r_wr_strobe <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_strobe <= w_strobe_nxt;
         r_frame_err <= w_err_nxt;
         if (!cs_n && w_done) begin
            if (r_state == ADDR) begin
               r_idx <= w_addr_idx;
               r_rnw <= w_addr_rnw;
               r_sel <= w_addr_idx;
            end else begin
               r_idx <= w_next_idx;
               r_sel <= w_next_idx;
            end
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_strobe_nxt[i]) r_regs[i*DATA_W +: DATA_W] <= w_cap[DATA_W-1:0];
         end
      end
   end

   assign serial_out = w_sout;
   assign reg_out    = r_regs;
   assign select_reg = r_sel;
   assign wr_strobe  = r_wr_strobe;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != ADDR) || (w_cnt != '0);

endmodule

// File: tb/tb_spi_cfg_reg_bank.sv
// Scoreboard bench for spi_cfg_reg_bank: directed SPI frames, expected strobes/errors/read words queued ahead of the DUT.
module tb_spi_cfg_reg_bank;

   localparam logic [31:0] RST = 32'h3C5A0F81;

   logic        sclk = 1'b0;
   logic        rstn;
   logic        cs_n;
   logic        serial_in;
   logic        serial_out;
   logic [31:0] ro_in;
   logic [31:0] reg_out;
   logic [6:0]  select_reg;
   logic [3:0]  wr_strobe;
   logic        frame_err;
   logic        busy;

   spi_cfg_reg_bank #(
      .DATA_W(8), .ADDR_W(8), .NUM_REGS(4), .RESET_VAL(RST), .RO_MASK(4'b0100)
   ) dut (
      .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .serial_in(serial_in), .serial_out(serial_out),
      .ro_in(ro_in), .reg_out(reg_out), .select_reg(select_reg), .wr_strobe(wr_strobe),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      string       tag;
      logic [36:0] val;
   } evt_t;

   evt_t        exp_evt[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  obs_rd[$];
   logic [31:0] model;
   int          nvec  = 0;
   int          nfail = 0;

   task automatic cmp(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic exp_write(input int idx, input logic [7:0] d, input string tag);
      evt_t e;
      model[idx*8 +: 8] = d;
      e.tag = tag;
      e.val = {1'b0, 4'(1 << idx), model};
      exp_evt.push_back(e);
   endtask

   task automatic exp_err(input string tag);
      evt_t e;
      e.tag = tag;
      e.val = {1'b1, 4'b0000, model};
      exp_evt.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge sclk);
         cs_n      = 1'b1;
         serial_in = 1'b0;
      end
   endtask

   // Address word, nw data words (wd LSB word first), then tail_bits of a partial word; cs_n left low.
   task automatic frame(input logic [7:0] addr, input int nw, input logic [31:0] wd, input int tail_bits);
      logic [7:0] rd;
      for (int b = 0; b < 8; b++) begin
         @(negedge sclk);
         cs_n      = 1'b0;
         serial_in = addr[b];
      end
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 8; b++) begin
            @(negedge sclk);
            rd[b]     = serial_out;
            serial_in = wd[w*8+b];
         end
         if (addr[7]) obs_rd.push_back(rd);
      end
      for (int b = 0; b < tail_bits; b++) begin
         @(negedge sclk);
         serial_in = 1'b1;
      end
   endtask

   initial begin : evt_monitor
      evt_t e;
      forever begin
         @(negedge sclk);
         if (wr_strobe != 4'b0000 || frame_err) begin
            if (exp_evt.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL unexpected event: got strobe=%b err=%b reg_out=%h, expected none",
                        wr_strobe, frame_err, reg_out);
            end else begin
               e = exp_evt.pop_front();
               cmp(e.tag, {frame_err, wr_strobe, reg_out}, e.val);
            end
         end
      end
   end

   initial begin : rd_monitor
      logic [7:0] o;
      forever begin
         @(negedge sclk);
         while (obs_rd.size() > 0) begin
            o = obs_rd.pop_front();
            if (exp_rd.size() == 0) begin
               nvec++;
               nfail++;
               $display("FAIL unexpected read word: got %h, expected none", o);
            end else begin
               cmp("read word", o, exp_rd.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end

   initial begin : stim
      rstn      = 1'b0;
      cs_n      = 1'b1;
      serial_in = 1'b0;
      ro_in     = 32'hEE5CDDCC;
      model     = RST;
      repeat (2) @(negedge sclk);
      cmp("reset reg_out", reg_out, RST);
      cmp("reset serial_out", serial_out, 0);
      cmp("reset wr_strobe", wr_strobe, 0);
      cmp("reset frame_err", frame_err, 0);
      cmp("reset busy", busy, 0);
      cmp("reset select_reg", select_reg, 0);
      rstn = 1'b1;
      idle(2);

      // Burst read of all four registers from 1 with wrap; reg2 is read-only.
      exp_rd.push_back(8'h0F);
      exp_rd.push_back(8'h5C);
      exp_rd.push_back(8'h3C);
      exp_rd.push_back(8'h81);
      frame(8'h81, 4, 32'h0, 0);
      idle(2);
      cmp("idle busy", busy, 0);

      exp_write(1, 8'hA5, "single write reg1");
      frame(8'h01, 1, 32'h000000A5, 0);
      idle(2);

      exp_write(3, 8'h11, "burst write reg3");
      exp_write(0, 8'h22, "burst write reg0 wrap");
      exp_write(1, 8'h33, "burst write reg1");
      frame(8'h03, 3, 32'h00332211, 0);
      idle(2);

      exp_err("ro write err");
      frame(8'h02, 1, 32'h000000FF, 0);
      idle(2);
      exp_rd.push_back(8'h5C);
      frame(8'h82, 1, 32'h0, 0);
      idle(2);

      exp_err("oor write err");
      frame(8'h09, 1, 32'h00000077, 0);
      idle(2);
      exp_rd.push_back(8'h00);
      exp_err("oor read err");
      frame(8'h89, 1, 32'h0, 0);
      idle(2);

      exp_err("abort partial word");
      frame(8'h03, 0, 32'h0, 3);
      @(negedge sclk);
      cmp("mid-frame busy", busy, 1);
      cmp("mid-frame select_reg", select_reg, 3);
      cs_n      = 1'b1;
      serial_in = 1'b0;
      idle(2);
      exp_write(0, 8'h5E, "write after abort");
      frame(8'h00, 1, 32'h0000005E, 0);
      idle(2);
      exp_rd.push_back(8'h5E);
      frame(8'h80, 1, 32'h0, 0);
      idle(2);

      exp_write(1, 8'h99, "write before reset");
      frame(8'h01, 1, 32'h00000099, 3);
      @(negedge sclk);
      cmp("burst select_reg", select_reg, 2);
      cmp("burst busy", busy, 1);
      rstn = 1'b0;
      @(negedge sclk);
      cmp("mid-burst reset reg_out", reg_out, RST);
      cmp("mid-burst reset busy", busy, 0);
      cmp("mid-burst reset select_reg", select_reg, 0);
      rstn  = 1'b1;
      cs_n  = 1'b1;
      model = RST;
      idle(2);
      exp_rd.push_back(8'h3C);
      frame(8'h83, 1, 32'h0, 0);
      idle(4);

      cmp("pending events", exp_evt.size(), 0);
      cmp("pending read words", exp_rd.size(), 0);
      cmp("unchecked read words", obs_rd.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
